subtractor_serial: RTL and testbench

SUBTRACTOR_SERIAL -- requirements
Module: subtractor_serial

---
 rtl/subtractor_serial.sv | 137 +++++++++++++
 tb/tb_subtractor_serial.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned/two's-complement subtractor: one bit per clock, LSB first,
// computed as a + ~b + 1 through a selectable 1-bit full-adder cell.
module subtractor_serial #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_a, cell_nb, cell_sum, cell_cout;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign cell_a  = a_q[0];
  assign cell_nb = ~b_q[0];

  // Both cell styles compute the same full add of a, ~b and the running carry.
  if (IMPL_TYPE == 0) begin : g_xor_mux
    logic prop;
    assign prop      = cell_a ^ cell_nb;
    assign cell_sum  = prop ^ carry_q;
    assign cell_cout = prop ? carry_q : cell_a;
  end else if (IMPL_TYPE == 1) begin : g_maj_not
    assign cell_cout = maj3(cell_a, cell_nb, carry_q);
    assign cell_sum  = maj3(~cell_cout, maj3(cell_a, cell_nb, ~carry_q), carry_q);
  end else begin : g_bad_impl
    $fatal(1, "Unsupported implementation for subtractor_serial: %0d", IMPL_TYPE);
    assign cell_sum  = 1'b0;
    assign cell_cout = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        diff_d  = {cell_sum, diff_q[WIDTH-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + 1'b1;
        // On the last bit the operand LSBs are the original sign bits.
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          borrow_d = ~cell_cout;
          ovf_d    = (cell_a != b_q[0]) && (cell_sum != cell_a);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_RUN) && (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed and back-to-back random checks of subtractor_serial at WIDTH 2/8/32,
// both cell styles side by side on shared stimulus.
module tb_subtractor_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_w = '0;
  logic [63:0] a_w [3];
  logic [63:0] b_w [3];
  logic [5:0]  busy_v, done_v, bo_v, ovf_v;
  logic [63:0] diff_v [6];
  logic [1:0]  st_v [6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance g: width index g/2 (2, 8, 32), cell style g%2.
  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int W = (g / 2 == 0) ? 2 : ((g / 2 == 1) ? 8 : 32);
    logic [W-1:0] d;
    subtractor_serial #(.WIDTH(W), .IMPL_TYPE(g % 2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_w[g/2]),
      .a          (a_w[g/2][W-1:0]),
      .b          (b_w[g/2][W-1:0]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .diff       (d),
      .borrow_out (bo_v[g]),
      .ovf        (ovf_v[g]),
      .dbg_state  (st_v[g])
    );
    assign diff_v[g] = 64'(d);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                output logic [63:0] d, output logic bo, output logic ov);
    logic [63:0] mask;
    longint sa, sb, sd, hi, lo;
    mask = (64'd1 << w) - 64'd1;
    d  = (av - bv) & mask;
    bo = (av < bv);
    sa = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sb = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    sd = sa - sb;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ov = (sd > hi) || (sd < lo);
  endfunction

  task automatic check_result(input string tag, input int wi, input logic [63:0] ed,
                              input logic eb, input logic eo);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_diff%0d", tag, i), diff_v[wi*2+i], ed);
      chk($sformatf("%s_borrow%0d", tag, i), 64'(bo_v[wi*2+i]), 64'(eb));
      chk($sformatf("%s_ovf%0d", tag, i), 64'(ovf_v[wi*2+i]), 64'(eo));
    end
  endtask

  // One 8-bit operation with a one-cycle start pulse; operands are scrambled after capture.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    @(negedge clk);
    a_w[1] = 64'(av); b_w[1] = 64'(bv); start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    a_w[1] = 64'(~av); b_w[1] = 64'(~bv);
    chk({tag, "_busy_run"}, 64'(busy_v[3:2]), 64'b11);
    lat = 0;
    while (!done_v[2] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_done1"}, 64'(done_v[3]), 64'd1);
    check_result(tag, 1, 64'(ed), eb, eo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done_v[3:2]), 64'd0);
    chk({tag, "_busy_idle"}, 64'(busy_v[3:2]), 64'd0);
    check_result({tag, "_hold"}, 1, 64'(ed), eb, eo);
  endtask

  task automatic run_random(input int wi, input int w, input int n);
    logic [63:0] mask, ca, cb, ed;
    logic eb, eo;
    int last_done, waited;
    mask = (64'd1 << w) - 64'd1;
    ca = {$urandom, $urandom} & mask;
    cb = {$urandom, $urandom} & mask;
    a_w[wi] = ca; b_w[wi] = cb; start_w[wi] = 1'b1;
    last_done = -1;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!done_v[wi*2] && waited < w + 10);
      if (!done_v[wi*2]) begin
        chk($sformatf("rnd_w%0d_timeout", w), 64'(done_v[wi*2]), 64'd1);
        break;
      end
      chk($sformatf("rnd_w%0d_done1", w), 64'(done_v[wi*2+1]), 64'd1);
      model(w, ca, cb, ed, eb, eo);
      check_result($sformatf("rnd_w%0d", w), wi, ed, eb, eo);
      if (last_done >= 0)
        chk($sformatf("rnd_w%0d_spacing", w), 64'(cyc - last_done), 64'(w + 2));
      last_done = cyc;
      ca = {$urandom, $urandom} & mask;
      cb = {$urandom, $urandom} & mask;
      if (k % 7 == 0) cb = ca;
      a_w[wi] = ca; b_w[wi] = cb;
    end
    start_w[wi] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [63:0] seen_diff;
    for (int i = 0; i < 3; i++) begin
      a_w[i] = '0;
      b_w[i] = '0;
    end

    // Reset state on every instance.
    repeat (2) @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("rst_busy%0d", g), 64'(busy_v[g]), 64'd0);
      chk($sformatf("rst_done%0d", g), 64'(done_v[g]), 64'd0);
      chk($sformatf("rst_diff%0d", g), diff_v[g], 64'd0);
      chk($sformatf("rst_borrow%0d", g), 64'(bo_v[g]), 64'd0);
      chk($sformatf("rst_ovf%0d", g), 64'(ovf_v[g]), 64'd0);
      chk($sformatf("rst_state%0d", g), 64'(st_v[g]), 64'd0);
    end
    rst_n = 1'b1;

    op8("v5m3", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
    op8("v3m5", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    op8("v0m0", 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    op8("v80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8("v7Fm01", 8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);
    op8("v7FmFF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Reset four cycles into an operation: outputs clear at once, no done follows.
    @(negedge clk);
    a_w[1] = 64'h33; b_w[1] = 64'h11; start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_v[3:2]), 64'd0);
    chk("abort_done", 64'(done_v[3:2]), 64'd0);
    check_result("abort", 1, 64'd0, 1'b0, 1'b0);
    chk("abort_state", 64'(st_v[2]), 64'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[2]) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    rst_n = 1'b1;
    a_w[1] = 64'h10; b_w[1] = 64'h01; start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    chk("post_rst_accept", 64'(busy_v[3:2]), 64'b11);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[2]) pulses++;
    end
    chk("post_rst_latency", 64'(pulses), 64'd1);
    check_result("post_rst", 1, 64'h0F, 1'b0, 1'b0);
    @(negedge clk);

    // A start arriving while busy is ignored.
    @(negedge clk);
    a_w[1] = 64'd9; b_w[1] = 64'd4; start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    repeat (2) @(negedge clk);
    a_w[1] = 64'd1; b_w[1] = 64'd2; start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    pulses = 0;
    seen_diff = '0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[2]) begin
        pulses++;
        seen_diff = diff_v[2];
      end
    end
    chk("ignore_pulses", 64'(pulses), 64'd1);
    chk("ignore_diff", seen_diff, 64'h05);
    chk("ignore_idle", 64'(busy_v[3:2]), 64'd0);

    run_random(0, 2, 300);
    run_random(1, 8, 300);
    run_random(2, 32, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
